// File: rtl/alu_issue_stage.sv
// Two-entry skid-buffered issue stage that decodes RV32I OP/OP-IMM into ALU operands.
// Define ALU_ISSUE_FWD_EN to bypass writeback data onto rs1/rs2 at accept time.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_b5,
  input  logic        in_is_imm,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_op_code,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic [7:0]  illegal_count
);

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_SLL     = 4'b0101;
  localparam logic [3:0] OP_SRL     = 4'b0110;
  localparam logic [3:0] OP_SRA     = 4'b0111;
  localparam logic [3:0] OP_SLT     = 4'b1000;
  localparam logic [3:0] OP_SLTU    = 4'b1001;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  state_t      state_q;
  entry_t      mainEntry_q;
  entry_t      skidEntry_q;
  entry_t      newEntry;
  logic        inReady_q;
  logic        outValid_q;
  logic [7:0]  illegalCount_q;
  logic [7:0]  illegalCount_d;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic [31:0] operandB;
  logic        isShift;
  logic        accept;
  logic        drain;

  assign accept = in_valid && inReady_q;
  assign drain  = outValid_q && out_ready;

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    rs1Val = in_rs1_data;
    rs2Val = in_rs2_data;
    if (wb_valid && (wb_rd != 5'd0) && (wb_rd == in_rs1_addr)) rs1Val = wb_data;
    if (!in_is_imm && wb_valid && (wb_rd != 5'd0) && (wb_rd == in_rs2_addr)) rs2Val = wb_data;
  end
`else
  logic unusedBypass;
  assign unusedBypass = ^{wb_valid, wb_rd, wb_data, in_rs1_addr, in_rs2_addr};
  assign rs1Val = in_rs1_data;
  assign rs2Val = in_rs2_data;
`endif

  // Shift amounts only use the low five bits, so the upper bits are cleared
  always_comb begin
    isShift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    operandB = in_is_imm ? in_imm : rs2Val;
    newEntry = '0;
    newEntry.a  = rs1Val;
    newEntry.b  = isShift ? {27'd0, operandB[4:0]} : operandB;
    newEntry.rd = in_rd;
    if (in_is_imm) newEntry.illegal = in_funct7_b5 && (in_funct3 == 3'b001);
    else           newEntry.illegal = in_funct7_b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
    case (in_funct3)
      3'b000:  newEntry.op = (in_funct7_b5 && !in_is_imm) ? OP_SUB : OP_ADD;
      3'b001:  newEntry.op = OP_SLL;
      3'b010:  newEntry.op = OP_SLT;
      3'b011:  newEntry.op = OP_SLTU;
      3'b100:  newEntry.op = OP_XOR;
      3'b101:  newEntry.op = in_funct7_b5 ? OP_SRA : OP_SRL;
      3'b110:  newEntry.op = OP_OR;
      default: newEntry.op = OP_AND;
    endcase
    if (newEntry.illegal) newEntry.op = OP_ILLEGAL;
  end

  assign illegalCount_d = (accept && newEntry.illegal && (illegalCount_q != 8'hFF))
                          ? illegalCount_q + 8'd1 : illegalCount_q;

  // Flush drops the held entries and any same-cycle input, but keeps the illegal tally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      inReady_q      <= 1'b1;
      outValid_q     <= 1'b0;
      mainEntry_q    <= '0;
      skidEntry_q    <= '0;
      illegalCount_q <= 8'd0;
    end else if (flush) begin
      state_q    <= EMPTY;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      illegalCount_q <= illegalCount_d;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            mainEntry_q <= newEntry;
            state_q     <= ONE;
            outValid_q  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            mainEntry_q <= newEntry;
          end else if (accept) begin
            skidEntry_q <= newEntry;
            state_q     <= FULL;
            inReady_q   <= 1'b0;
          end else if (drain) begin
            state_q    <= EMPTY;
            outValid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            mainEntry_q <= skidEntry_q;
            state_q     <= ONE;
            inReady_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = inReady_q;
  assign out_valid     = outValid_q;
  assign out_a         = mainEntry_q.a;
  assign out_b         = mainEntry_q.b;
  assign out_op_code   = mainEntry_q.op;
  assign out_rd        = mainEntry_q.rd;
  assign out_illegal   = mainEntry_q.illegal;
  assign illegal_count = illegalCount_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, corner sequences and a randomized queue model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_funct7_b5 = 1'b0;
  logic        in_is_imm = 1'b0;
  logic [4:0]  in_rs1_addr = 5'd0;
  logic [4:0]  in_rs2_addr = 5'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_rs1_data = 32'd0;
  logic [31:0] in_rs2_data = 32'd0;
  logic [31:0] in_imm = 32'd0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_op_code;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  int total = 0;
  int bad = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5), .in_is_imm(in_is_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op_code(out_op_code), .out_rd(out_rd),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } expEntry_t;

  typedef struct {
    logic [2:0]  f3;
    logic        b5;
    logic        isImm;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  expOp;
    logic [31:0] expB;
    logic        expIll;
  } vec_t;

  expEntry_t refQ[$];
  int        refCount = 0;
  vec_t      vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] f3, input logic b5,
                               input logic isImm, input logic [4:0] rs1a, input logic [4:0] rd,
                               input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm);
    in_valid     = valid;
    in_funct3    = f3;
    in_funct7_b5 = b5;
    in_is_imm    = isImm;
    in_rs1_addr  = rs1a;
    in_rs2_addr  = 5'd0;
    in_rd        = rd;
    in_rs1_data  = rs1d;
    in_rs2_data  = rs2d;
    in_imm       = imm;
  endtask

  task automatic doReset();
    rst = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    stepClk();
    stepClk();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    wb_valid = 1'b0;
    refQ.delete();
    refCount = 0;
  endtask

  // Reference decode of whatever is on the input pins right now
  function automatic expEntry_t refDecode();
    expEntry_t   r;
    logic [31:0] r2;
    r.a = in_rs1_data;
    r2  = in_rs2_data;
`ifdef ALU_ISSUE_FWD_EN
    if (wb_valid && wb_rd != 0 && wb_rd == in_rs1_addr) r.a = wb_data;
    if (!in_is_imm && wb_valid && wb_rd != 0 && wb_rd == in_rs2_addr) r2 = wb_data;
`endif
    r.b  = in_is_imm ? in_imm : r2;
    r.rd = in_rd;
    case (in_funct3)
      3'd0: r.op = (in_funct7_b5 && !in_is_imm) ? 4'd1 : 4'd0;
      3'd1: r.op = 4'd5;
      3'd2: r.op = 4'd8;
      3'd3: r.op = 4'd9;
      3'd4: r.op = 4'd4;
      3'd5: r.op = in_funct7_b5 ? 4'd7 : 4'd6;
      3'd6: r.op = 4'd3;
      default: r.op = 4'd2;
    endcase
    if (in_funct3 == 3'd1 || in_funct3 == 3'd5) r.b = r.b % 32;
    if (in_is_imm) r.ill = in_funct7_b5 && in_funct3 == 3'd1;
    else           r.ill = in_funct7_b5 && !(in_funct3 == 3'd0 || in_funct3 == 3'd5);
    if (r.ill) r.op = 4'd15;
    return r;
  endfunction

  task automatic modelEdge();
    bit acc;
    bit drn;
    acc = in_valid && refQ.size() < 2;
    drn = refQ.size() > 0 && out_ready;
    if (rst) begin
      refQ.delete();
      refCount = 0;
    end else if (flush) begin
      refQ.delete();
    end else begin
      if (drn) void'(refQ.pop_front());
      if (acc) begin
        expEntry_t e;
        e = refDecode();
        refQ.push_back(e);
        if (e.ill && refCount < 255) refCount++;
      end
    end
  endtask

  initial begin
    int expCount;

    // Reset with flush and a valid input pending; reset must win
    doReset();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_a", out_a, 32'd0);
    checkOutput("rst_out_b", out_b, 32'd0);
    checkOutput("rst_op", {28'd0, out_op_code}, 32'd0);
    checkOutput("rst_rd", {27'd0, out_rd}, 32'd0);
    checkOutput("rst_illegal", {31'd0, out_illegal}, 32'd0);
    checkOutput("rst_count", {24'd0, illegal_count}, 32'd0);

    // Basic ADD, one-cycle latency
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd7, 32'd2, 32'd3, 32'd0);
    stepClk();
    in_valid = 1'b0;
    checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_op", {28'd0, out_op_code}, 32'd0);
    checkOutput("add_a", out_a, 32'd2);
    checkOutput("add_b", out_b, 32'd3);
    stepClk();
    checkOutput("add_drained", {31'd0, out_valid}, 32'd0);

    // Decode vectors streamed back-to-back with the consumer always ready
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'd3,          32'd0,          4'b0000, 32'd3,          1'b0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'd4,          32'd0,          4'b0001, 32'd4,          1'b0};
    vecs[2]  = '{3'b000, 1'b1, 1'b1, 32'd0,          32'h0000_0400,  4'b0000, 32'h0000_0400,  1'b0};
    vecs[3]  = '{3'b001, 1'b0, 1'b0, 32'h25,         32'd0,          4'b0101, 32'd5,          1'b0};
    vecs[4]  = '{3'b001, 1'b1, 1'b1, 32'd0,          32'd3,          4'b1111, 32'd3,          1'b1};
    vecs[5]  = '{3'b010, 1'b0, 1'b0, 32'd7,          32'd0,          4'b1000, 32'd7,          1'b0};
    vecs[6]  = '{3'b011, 1'b0, 1'b1, 32'd0,          32'hFFFF_FFFF,  4'b1001, 32'hFFFF_FFFF,  1'b0};
    vecs[7]  = '{3'b100, 1'b0, 1'b0, 32'h1234_5678,  32'd0,          4'b0100, 32'h1234_5678,  1'b0};
    vecs[8]  = '{3'b101, 1'b0, 1'b1, 32'd0,          32'h0000_0421,  4'b0110, 32'd1,          1'b0};
    vecs[9]  = '{3'b101, 1'b1, 1'b1, 32'd0,          32'h0000_0401,  4'b0111, 32'd1,          1'b0};
    vecs[10] = '{3'b101, 1'b1, 1'b0, 32'hFFFF_FFE3,  32'd0,          4'b0111, 32'd3,          1'b0};
    vecs[11] = '{3'b110, 1'b0, 1'b0, 32'hA5A5_0000,  32'd0,          4'b0011, 32'hA5A5_0000,  1'b0};
    vecs[12] = '{3'b111, 1'b0, 1'b1, 32'd0,          32'h55,         4'b0010, 32'h55,         1'b0};
    vecs[13] = '{3'b110, 1'b1, 1'b0, 32'd9,          32'd0,          4'b1111, 32'd9,          1'b1};
    vecs[14] = '{3'b111, 1'b1, 1'b0, 32'd11,         32'd0,          4'b1111, 32'd11,         1'b1};
    vecs[15] = '{3'b010, 1'b1, 1'b1, 32'd0,          32'h10,         4'b1000, 32'h10,         1'b0};
    vecs[16] = '{3'b100, 1'b1, 1'b0, 32'd13,         32'd0,          4'b1111, 32'd13,         1'b1};
    expCount = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, vecs[i].f3, vecs[i].b5, vecs[i].isImm, 5'd0, 5'(i + 1),
                    32'h1000_0000 + i, vecs[i].rs2, vecs[i].imm);
      stepClk();
      if (vecs[i].expIll) expCount++;
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d_op", i), {28'd0, out_op_code}, {28'd0, vecs[i].expOp});
      checkOutput($sformatf("vec%0d_a", i), out_a, 32'h1000_0000 + i);
      checkOutput($sformatf("vec%0d_b", i), out_b, vecs[i].expB);
      checkOutput($sformatf("vec%0d_rd", i), {27'd0, out_rd}, i + 1);
      checkOutput($sformatf("vec%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].expIll});
      checkOutput($sformatf("vec%0d_count", i), {24'd0, illegal_count}, expCount);
    end
    in_valid = 1'b0;
    stepClk();

    // Backpressure: two accepted, third refused, then drain in order
    doReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 5'd10, 32'd100, 32'd1, 32'd0);
    checkOutput("bp_ready0", {31'd0, in_ready}, 32'd1);
    stepClk();
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 5'd0, 5'd11, 32'd200, 32'd2, 32'd0);
    checkOutput("bp_ready1", {31'd0, in_ready}, 32'd1);
    stepClk();
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 5'd0, 5'd12, 32'd300, 32'd3, 32'd0);
    checkOutput("bp_ready2", {31'd0, in_ready}, 32'd0);
    stepClk();
    in_valid = 1'b0;
    checkOutput("bp_hold_rd", {27'd0, out_rd}, 32'd10);
    checkOutput("bp_hold_a", out_a, 32'd100);
    out_ready = 1'b1;
    stepClk();
    checkOutput("bp_second_rd", {27'd0, out_rd}, 32'd11);
    checkOutput("bp_second_a", out_a, 32'd200);
    checkOutput("bp_second_valid", {31'd0, out_valid}, 32'd1);
    stepClk();
    checkOutput("bp_empty_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_empty_ready", {31'd0, in_ready}, 32'd1);

    // Flush beats a same-cycle accept, in ONE and in FULL
    doReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0);
    stepClk();
    checkOutput("fl_one_count", {24'd0, illegal_count}, 32'd1);
    flush = 1'b1;
    stepClk();
    flush = 1'b0;
    checkOutput("fl_one_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("fl_one_count_kept", {24'd0, illegal_count}, 32'd1);
    stepClk();
    stepClk();
    checkOutput("fl_full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fl_full_count", {24'd0, illegal_count}, 32'd3);
    flush = 1'b1;
    stepClk();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_full_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("fl_full_ready_after", {31'd0, in_ready}, 32'd1);
    checkOutput("fl_full_count_kept", {24'd0, illegal_count}, 32'd3);

    // Saturation of the illegal counter
    doReset();
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 254; i++) stepClk();
    checkOutput("sat_254", {24'd0, illegal_count}, 32'd254);
    stepClk();
    stepClk();
    checkOutput("sat_256", {24'd0, illegal_count}, 32'd255);
    stepClk();
    in_valid = 1'b0;
    checkOutput("sat_257", {24'd0, illegal_count}, 32'd255);
    checkOutput("sat_op", {28'd0, out_op_code}, 32'd15);

    // Writeback bypass on rs1
    doReset();
    out_ready = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 5'd5, 5'd3, 32'h1111_1111, 32'd0, 32'd0);
    stepClk();
`ifdef ALU_ISSUE_FWD_EN
    checkOutput("fwd_hit_a", out_a, 32'hDEAD_BEEF);
`else
    checkOutput("fwd_hit_a", out_a, 32'h1111_1111);
`endif
    wb_rd = 5'd0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 5'd3, 32'h2222_2222, 32'd0, 32'd0);
    stepClk();
    checkOutput("fwd_x0_a", out_a, 32'h2222_2222);
    in_valid = 1'b0;
    wb_valid = 1'b0;
    stepClk();

    // Randomized traffic against the queue model
    doReset();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom % 80) == 0;
      flush        = ($urandom % 20) == 0;
      in_valid     = ($urandom % 4) != 0;
      out_ready    = ($urandom % 3) != 0;
      in_funct3    = 3'($urandom);
      in_funct7_b5 = ($urandom % 3) == 0;
      in_is_imm    = $urandom % 2;
      in_rs1_addr  = 5'($urandom % 4);
      in_rs2_addr  = 5'($urandom % 4);
      in_rd        = 5'($urandom);
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      wb_valid     = $urandom % 2;
      wb_rd        = 5'($urandom % 4);
      wb_data      = $urandom;
      checkOutput("rnd_valid", {31'd0, out_valid}, {31'd0, refQ.size() > 0});
      checkOutput("rnd_ready", {31'd0, in_ready}, {31'd0, refQ.size() < 2});
      checkOutput("rnd_count", {24'd0, illegal_count}, refCount);
      if (refQ.size() > 0) begin
        checkOutput("rnd_a", out_a, refQ[0].a);
        checkOutput("rnd_b", out_b, refQ[0].b);
        checkOutput("rnd_op", {28'd0, out_op_code}, {28'd0, refQ[0].op});
        checkOutput("rnd_rd", {27'd0, out_rd}, {27'd0, refQ[0].rd});
        checkOutput("rnd_ill", {31'd0, out_illegal}, {31'd0, refQ[0].ill});
      end
      modelEdge();
      stepClk();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
